// File: rtl/uart_config_sequencer.sv
// UART link configuration handshake sequencer.
// Initiator: sends SYN plus the local configuration byte, then waits for ACK.
// If no ACK arrives it resends, and after the last resend it falls back to the
// standard configuration. Responder: on a received SYN it takes the next byte
// as the remote configuration, strobes it into STR and answers with ACK.
module uart_config_sequencer #(
    parameter logic [7:0] SYN_CHAR       = 8'hF1,
    parameter logic [7:0] ACK_CHAR       = 8'hF2,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         MAX_RETRY      = 3
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       send_req_i,
    input  logic       enable_i,
    input  logic [1:0] cfg_data_width_i,
    input  logic [1:0] cfg_parity_mode_i,
    input  logic [1:0] cfg_stop_bits_i,
    input  logic       tx_idle_i,
    input  logic       tx_done_i,
    output logic       tx_req_o,
    output logic [7:0] tx_data_o,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    output logic       str_en_o,
    output logic [1:0] data_width_o,
    output logic [1:0] parity_mode_o,
    output logic [1:0] stop_bits_o,
    output logic       configuration_done_o,
    output logic       set_std_config_o,
    output logic       busy_o
);

    // Guard the widths so degenerate parameter values still elaborate.
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_WAIT,
        ST_TX_SYN,
        ST_TX_CFG,
        ST_WAIT_ACK,
        ST_RX_CFG,
        ST_TX_ACK
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_next;
    logic [RW-1:0]   r_retry;
    logic [RW-1:0]   w_retry_next;
    logic            r_sent;        // request for the current byte already issued
    logic            w_sent_next;
    logic            r_pending;     // local request deferred behind a responder handshake
    logic            w_pending_next;
    logic [5:0]      r_cfg;         // local fields captured when leaving IDLE
    logic [5:0]      w_cfg_next;
    logic [5:0]      r_remote;      // last remote fields written into STR
    logic [5:0]      w_remote_next;
    logic [5:0]      w_remote_view;

    logic w_rx_syn;
    logic w_rx_ack;
    logic w_timeout;

    assign w_rx_syn  = rx_valid_i && (rx_data_i == SYN_CHAR);
    assign w_rx_ack  = rx_valid_i && (rx_data_i == ACK_CHAR);
    assign w_timeout = (r_timer == TIMER_LAST);

    // State and bookkeeping registers; asynchronous reset drops everything in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_retry   <= '0;
            r_sent    <= 1'b0;
            r_pending <= 1'b0;
            r_cfg     <= '0;
            r_remote  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_retry   <= w_retry_next;
            r_sent    <= w_sent_next;
            r_pending <= w_pending_next;
            r_cfg     <= w_cfg_next;
            r_remote  <= w_remote_next;
        end
    end

    // Next-state logic and the single-cycle strobes towards TX, STR and the register block.
    always_comb begin
        w_state_next     = r_state;
        w_timer_next     = r_timer;
        w_retry_next     = r_retry;
        w_sent_next      = r_sent;
        w_pending_next   = r_pending;
        w_cfg_next       = r_cfg;
        w_remote_next    = r_remote;
        tx_req_o         = 1'b0;
        tx_data_o        = 8'h00;
        str_en_o         = 1'b0;
        set_std_config_o = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (enable_i && w_rx_syn) begin
                    // Responder wins; a coincident local request waits its turn.
                    w_state_next = ST_RX_CFG;
                    if (send_req_i) begin
                        w_pending_next = 1'b1;
                    end
                end else if (enable_i && (send_req_i || r_pending)) begin
                    w_state_next   = ST_TX_WAIT;
                    w_cfg_next     = {cfg_data_width_i, cfg_parity_mode_i, cfg_stop_bits_i};
                    w_pending_next = 1'b0;
                end else if (!enable_i) begin
                    w_pending_next = 1'b0;
                end
            end
            ST_TX_WAIT: begin
                if (tx_idle_i) begin
                    w_state_next = ST_TX_SYN;
                end
            end
            ST_TX_SYN: begin
                tx_data_o = SYN_CHAR;
                if (!r_sent) begin
                    if (tx_idle_i) begin
                        tx_req_o    = 1'b1;
                        w_sent_next = 1'b1;
                    end
                end else if (tx_done_i) begin
                    w_state_next = ST_TX_CFG;
                end
            end
            ST_TX_CFG: begin
                tx_data_o = {2'b00, r_cfg};
                if (!r_sent) begin
                    if (tx_idle_i) begin
                        tx_req_o    = 1'b1;
                        w_sent_next = 1'b1;
                    end
                end else if (tx_done_i) begin
                    w_state_next = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (w_rx_ack) begin
                    w_state_next = ST_IDLE;
                end else if (w_timeout) begin
                    if (r_retry < RETRY_LAST) begin
                        w_retry_next = r_retry + RW'(1);
                        w_state_next = ST_TX_WAIT;
                    end else begin
                        set_std_config_o = 1'b1;
                        w_state_next     = ST_IDLE;
                    end
                end
            end
            ST_RX_CFG: begin
                if (send_req_i) begin
                    w_pending_next = 1'b1;
                end
                if (rx_valid_i) begin
                    str_en_o      = 1'b1;
                    w_remote_next = rx_data_i[5:0];
                    w_state_next  = ST_TX_ACK;
                end else if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_TX_ACK: begin
                if (send_req_i) begin
                    w_pending_next = 1'b1;
                end
                tx_data_o = ACK_CHAR;
                if (!r_sent) begin
                    if (tx_idle_i) begin
                        tx_req_o    = 1'b1;
                        w_sent_next = 1'b1;
                    end
                end else if (tx_done_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Timer and issue flag restart on every state change; the timer only runs while waiting.
        if (w_state_next != r_state) begin
            w_timer_next = '0;
            w_sent_next  = 1'b0;
        end else if ((r_state == ST_WAIT_ACK) || (r_state == ST_RX_CFG)) begin
            w_timer_next = r_timer + TW'(1);
        end else begin
            w_timer_next = '0;
        end

        if ((w_state_next == ST_IDLE) && (r_state != ST_IDLE)) begin
            w_retry_next = '0;
        end
    end

    // Remote fields follow the received byte during the strobe so STR captures them that cycle.
    assign w_remote_view = str_en_o ? rx_data_i[5:0] : r_remote;

    assign data_width_o         = w_remote_view[5:4];
    assign parity_mode_o        = w_remote_view[3:2];
    assign stop_bits_o          = w_remote_view[1:0];
    assign configuration_done_o = (r_state == ST_IDLE);
    assign busy_o               = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_config_sequencer.sv
// Bench for uart_config_sequencer: directed scenarios, a behavioural transmitter,
// and an expected-transaction scoreboard checked on every cycle.
module tb_uart_config_sequencer;

    // Timeout shortened so the 50-cycle ACK case and the retry/fallback case share one instance.
    localparam int TO    = 60;
    localparam int MR    = 2;
    localparam int FRAME = 10;

    logic       clk;
    logic       rst_n;
    logic       send_req;
    logic       enable;
    logic [1:0] cfg_dw;
    logic [1:0] cfg_pm;
    logic [1:0] cfg_sb;
    logic       tx_idle;
    logic       tx_done;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       str_en;
    logic [1:0] dw;
    logic [1:0] pm;
    logic [1:0] sb;
    logic       done;
    logic       set_std;
    logic       busy;

    uart_config_sequencer #(
        .SYN_CHAR       (8'hF1),
        .ACK_CHAR       (8'hF2),
        .TIMEOUT_CYCLES (TO),
        .MAX_RETRY      (MR)
    ) dut (
        .clk_i                (clk),
        .rst_n_i              (rst_n),
        .send_req_i           (send_req),
        .enable_i             (enable),
        .cfg_data_width_i     (cfg_dw),
        .cfg_parity_mode_i    (cfg_pm),
        .cfg_stop_bits_i      (cfg_sb),
        .tx_idle_i            (tx_idle),
        .tx_done_i            (tx_done),
        .tx_req_o             (tx_req),
        .tx_data_o            (tx_data),
        .rx_valid_i           (rx_valid),
        .rx_data_i            (rx_data),
        .str_en_o             (str_en),
        .data_width_o         (dw),
        .parity_mode_o        (pm),
        .stop_bits_o          (sb),
        .configuration_done_o (done),
        .set_std_config_o     (set_std),
        .busy_o               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected transactions, written only by the stimulus process.
    logic [7:0] exp_tx[$];
    logic [5:0] exp_str[$];
    int         exp_std = 0;
    // Progress through the expectations, owned by the compare process.
    int         tx_rd   = 0;
    int         str_rd  = 0;
    int         n_std   = 0;
    logic [7:0] obs_tx[$];
    // Completed frames, owned by the transmitter model.
    int         n_txdone = 0;

    function automatic logic [7:0] cfg_byte(input logic [1:0] d, input logic [1:0] p, input logic [1:0] s);
        return {2'b00, d, p, s};
    endfunction

    // A local request puts SYN and then the configuration byte on the line.
    task automatic expect_request(input logic [1:0] d, input logic [1:0] p, input logic [1:0] s);
        exp_tx.push_back(8'hF1);
        exp_tx.push_back(cfg_byte(d, p, s));
    endtask

    // A remote configuration byte produces one STR write and one ACK.
    task automatic expect_remote(input logic [7:0] b);
        exp_str.push_back(b[5:0]);
        exp_tx.push_back(8'hF2);
    endtask

    // Compare process: every cycle, mid-period.
    initial begin
        forever begin
            @(negedge clk);
            check("busy_vs_done", busy, !done);
            if (tx_req) begin
                check("tx_req_needs_idle", tx_idle, 1);
                obs_tx.push_back(tx_data);
                if (tx_rd < exp_tx.size()) begin
                    check("tx_byte", tx_data, exp_tx[tx_rd]);
                    tx_rd++;
                end else begin
                    check("tx_unexpected_req", tx_req, 0);
                end
            end
            if (str_en) begin
                check("str_in_handshake", busy, 1);
                if (str_rd < exp_str.size()) begin
                    check("str_fields", {dw, pm, sb}, exp_str[str_rd]);
                    str_rd++;
                end else begin
                    check("str_unexpected", str_en, 0);
                end
            end
            if (set_std) begin
                if (n_std < exp_std) begin
                    check("std_in_handshake", busy, 1);
                    n_std++;
                end else begin
                    check("std_unexpected", set_std, 0);
                end
            end
        end
    end

    // Transmitter model: accepts a request, stays busy FRAME cycles, then pulses done.
    initial begin
        tx_idle = 1'b1;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_req === 1'b1) begin
                @(posedge clk);
                #1 tx_idle = 1'b0;
                repeat (FRAME) @(posedge clk);
                #1;
                tx_done = 1'b1;
                tx_idle = 1'b1;
                n_txdone++;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_txdone(input int target, input int budget, input string name);
        int k = 0;
        while (n_txdone < target && k < budget) begin
            tick(1);
            k++;
        end
        check(name, (n_txdone >= target), 1);
    endtask

    task automatic wait_done_high(input int budget, input string name);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        check(name, done, 1);
    endtask

    task automatic wait_tx_consumed(input int budget, input string name);
        int k = 0;
        while (tx_rd < exp_tx.size() && k < budget) begin
            tick(1);
            k++;
        end
        check(name, tx_rd, exp_tx.size());
    endtask

    int base_tx;
    int base_done;
    int n_syn;

    initial begin
        rst_n    = 1'b0;
        send_req = 1'b0;
        enable   = 1'b0;
        cfg_dw   = 2'd0;
        cfg_pm   = 2'd0;
        cfg_sb   = 2'd0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Reset state
        #2;
        check("rst_done", done, 1);
        check("rst_busy", busy, 0);
        check("rst_tx_req", tx_req, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_str_en", str_en, 0);
        check("rst_set_std", set_std, 0);
        check("rst_fields", {dw, pm, sb}, 6'h00);
        tick(2);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick(2);

        // Local request 3/1/0, ACK 50 cycles after the configuration byte
        base_tx   = obs_tx.size();
        base_done = n_txdone;
        cfg_dw = 2'd3; cfg_pm = 2'd1; cfg_sb = 2'd0;
        expect_request(2'd3, 2'd1, 2'd0);
        send_req = 1'b1;
        tick(1);
        send_req = 1'b0;
        check("s1_done_low_after_req", done, 0);
        wait_txdone(base_done + 2, 200, "s1_two_frames_sent");
        tick(49);
        check("s1_done_low_before_ack", done, 0);
        rx_valid = 1'b1; rx_data = 8'hF2;
        tick(1);
        rx_valid = 1'b0;
        check("s1_done_high_after_ack", done, 1);
        check("s1_bytes_consumed", tx_rd, exp_tx.size());
        check("s1_syn_literal", obs_tx[base_tx], 8'hF1);
        check("s1_cfg_literal", obs_tx[base_tx + 1], 8'h34);
        tick(3);

        // Remote F1 then 0x1B
        base_tx   = obs_tx.size();
        base_done = n_txdone;
        expect_remote(8'h1B);
        rx_valid = 1'b1; rx_data = 8'hF1;
        tick(1);
        rx_valid = 1'b0;
        check("s2_done_low_in_rx", done, 0);
        tick(3);
        rx_valid = 1'b1; rx_data = 8'h1B;
        #1;
        check("s2_str_en", str_en, 1);
        check("s2_fields_literal", {dw, pm, sb}, 6'b01_10_11);
        tick(1);
        rx_valid = 1'b0;
        #1;
        check("s2_str_en_single", str_en, 0);
        check("s2_fields_held", {dw, pm, sb}, 6'b01_10_11);
        wait_done_high(100, "s2_done_returns");
        check("s2_ack_frame_done", n_txdone, base_done + 1);
        check("s2_ack_literal", obs_tx[base_tx], 8'hF2);
        tick(3);

        // No ACK: MR resends, then fallback
        base_tx = obs_tx.size();
        cfg_dw = 2'd1; cfg_pm = 2'd0; cfg_sb = 2'd2;
        for (int r = 0; r <= MR; r++) begin
            expect_request(2'd1, 2'd0, 2'd2);
        end
        exp_std = exp_std + 1;
        send_req = 1'b1;
        tick(1);
        send_req = 1'b0;
        wait_done_high(3 * (TO + 4 * FRAME + 20), "s3_fallback_idle");
        check("s3_std_pulses", n_std, exp_std);
        check("s3_all_pairs_sent", tx_rd, exp_tx.size());
        n_syn = 0;
        for (int i = base_tx; i < obs_tx.size(); i++) begin
            if (obs_tx[i] == 8'hF1) n_syn++;
        end
        check("s3_syn_count_literal", n_syn, 3);
        check("s3_cfg_literal", obs_tx[base_tx + 1], 8'h12);
        tick(5);
        check("s3_stays_idle", done, 1);

        // Simultaneous request and remote SYN: responder first, then the pending request
        base_tx   = obs_tx.size();
        base_done = n_txdone;
        cfg_dw = 2'd2; cfg_pm = 2'd3; cfg_sb = 2'd1;
        expect_remote(8'h05);
        expect_request(2'd2, 2'd3, 2'd1);
        send_req = 1'b1;
        rx_valid = 1'b1; rx_data = 8'hF1;
        tick(1);
        send_req = 1'b0;
        rx_valid = 1'b0;
        tick(2);
        rx_valid = 1'b1; rx_data = 8'h05;
        #1;
        check("s4_responder_first", str_en, 1);
        tick(1);
        rx_valid = 1'b0;
        wait_tx_consumed(200, "s4_all_bytes_sent");
        wait_txdone(base_done + 3, 100, "s4_three_frames");
        check("s4_ack_literal", obs_tx[base_tx], 8'hF2);
        check("s4_syn_literal", obs_tx[base_tx + 1], 8'hF1);
        check("s4_cfg_literal", obs_tx[base_tx + 2], 8'h2D);
        tick(5);
        check("s4_waiting_ack", done, 0);
        rx_valid = 1'b1; rx_data = 8'hF2;
        tick(1);
        rx_valid = 1'b0;
        check("s4_done_after_ack", done, 1);
        tick(3);

        // Remote SYN then silence: exact timeout, no STR write, no transmit
        base_tx = obs_tx.size();
        rx_valid = 1'b1; rx_data = 8'hF1;
        tick(1);
        rx_valid = 1'b0;
        check("s5_done_low", done, 0);
        tick(TO - 1);
        check("s5_still_waiting_last_cycle", done, 0);
        tick(1);
        check("s5_timeout_idle", done, 1);
        check("s5_no_tx", obs_tx.size(), base_tx);
        check("s5_no_str", str_rd, exp_str.size());
        tick(3);

        // Reset during WAIT_ACK
        base_done = n_txdone;
        cfg_dw = 2'd0; cfg_pm = 2'd0; cfg_sb = 2'd0;
        expect_request(2'd0, 2'd0, 2'd0);
        send_req = 1'b1;
        tick(1);
        send_req = 1'b0;
        wait_txdone(base_done + 2, 200, "s6_two_frames_sent");
        tick(5);
        check("s6_in_wait_ack", done, 0);
        rst_n = 1'b0;
        #1;
        check("s6_rst_done", done, 1);
        check("s6_rst_busy", busy, 0);
        check("s6_rst_tx_data", tx_data, 8'h00);
        check("s6_rst_tx_req", tx_req, 0);
        check("s6_rst_fields", {dw, pm, sb}, 6'h00);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        rx_valid = 1'b1; rx_data = 8'hF2;
        tick(1);
        rx_valid = 1'b0;
        tick(TO + 10);
        check("s6_ack_ignored_idle", done, 1);
        check("s6_no_retry_after_reset", tx_rd, exp_tx.size());

        // enable low blocks both paths and leaves nothing pending
        enable   = 1'b0;
        send_req = 1'b1;
        rx_valid = 1'b1; rx_data = 8'hF1;
        tick(1);
        send_req = 1'b0;
        rx_valid = 1'b0;
        check("s7_disabled_idle", done, 1);
        tick(3);
        enable = 1'b1;
        tick(3);
        check("s7_nothing_pending", done, 1);
        rx_valid = 1'b1; rx_data = 8'h1B;
        tick(1);
        rx_valid = 1'b0;
        tick(2);
        check("s7_stray_byte_ignored", done, 1);
        check("s7_no_str", str_rd, exp_str.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_config_sequencer.md
Name: uart_config_sequencer

Overview:
- Sequences the link-level configuration handshake between two UART controllers.
- When the local configuration register block requests a change, it sends SYN plus the new configuration through the transmitter, waits for ACK, and retries or falls back to the standard configuration on timeout.
- When the remote side initiates, it receives the configuration, writes it into STR, and replies ACK.
- Sits between the configuration registers, transmitter and receiver; drives configuration_done to the register block.

Parameters:
- SYN_CHAR, 8'hF1, configuration request marker byte.
- ACK_CHAR, 8'hF2, configuration acknowledge byte.
- TIMEOUT_CYCLES, 100000, clk_i cycles to wait for ACK or for the configuration byte after SYN.
- MAX_RETRY, 3, number of resends after the first attempt before fallback.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- send_req_i  in  1  local configuration change request (level or pulse).
- enable_i  in  1  configuration requests enabled (CTR.ENREQ).
- cfg_data_width_i  in  2  new local DWID.
- cfg_parity_mode_i  in  2  new local PMID.
- cfg_stop_bits_i  in  2  new local SBID.
- tx_idle_i  in  1  transmitter idle.
- tx_done_i  in  1  1-cycle pulse: current frame fully sent.
- tx_req_o  out  1  1-cycle pulse: transmit tx_data_o.
- tx_data_o  out  8  byte to transmit.
- rx_valid_i  in  1  1-cycle pulse: rx_data_i holds a received byte.
- rx_data_i  in  8  received byte.
- str_en_o  out  1  1-cycle write strobe of remote fields into STR.
- data_width_o  out  2  remote DWID.
- parity_mode_o  out  2  remote PMID.
- stop_bits_o  out  2  remote SBID.
- configuration_done_o  out  1  high when no handshake is in progress.
- set_std_config_o  out  1  1-cycle pulse: retries exhausted.
- busy_o  out  1  handshake in progress (inverse of configuration_done_o).

Behaviour:
- Reset values: state IDLE; configuration_done_o=1; busy_o=0; all pulses=0; tx_data_o=0; data_width_o, parity_mode_o, stop_bits_o=0; counters=0.
- FSM states: IDLE, TX_WAIT, TX_SYN, TX_CFG, WAIT_ACK, RX_CFG, TX_ACK.

Initiator path:
- IDLE -> TX_WAIT when send_req_i & enable_i.
- TX_WAIT -> TX_SYN when tx_idle_i.
- TX_SYN: one-cycle tx_req_o with tx_data_o=SYN_CHAR; advance to TX_CFG on tx_done_i.
- TX_CFG: one-cycle tx_req_o with tx_data_o={2'b00, DWID, PMID, SBID}, fields captured at the IDLE exit; advance to WAIT_ACK on tx_done_i.
- WAIT_ACK, rx_valid_i & rx_data_i==ACK_CHAR -> IDLE.
- WAIT_ACK, other received byte: ignored; the timer keeps running.
- WAIT_ACK, timer reaches TIMEOUT_CYCLES-1 with retry<MAX_RETRY: retry++, -> TX_WAIT.
- WAIT_ACK, timeout with retry==MAX_RETRY: set_std_config_o pulse, -> IDLE.

Responder path:
- IDLE with rx_valid_i & rx_data_i==SYN_CHAR & enable_i -> RX_CFG, timer cleared.
- RX_CFG, next rx_valid_i: str_en_o pulse in the same cycle; data_width_o/parity_mode_o/stop_bits_o = rx_data_i[5:4]/[3:2]/[1:0], registered and held; -> TX_ACK.
- RX_CFG timeout -> IDLE, no STR write.
- TX_ACK: wait tx_idle_i, issue one-cycle tx_req_o with ACK_CHAR, wait tx_done_i -> IDLE.

Common rules:
- configuration_done_o=0 in every non-IDLE state.
- A 1->0->1 transition signals completion, so the register block's edge detector commits the configuration.
- Timer: counter of width $clog2(TIMEOUT_CYCLES), cleared on entry to WAIT_ACK and RX_CFG, increments every cycle in those states.
- Retry counter: width $clog2(MAX_RETRY+1), cleared on IDLE entry.
- Simultaneous send_req_i and received SYN in IDLE: responder wins. send_req_i is latched into a pending flag and serviced on return to IDLE if still enabled.
- SYN received while in the initiator path is ignored.
- enable_i low in IDLE blocks both paths, and SYN bytes are ignored. enable_i deassertion mid-handshake does not abort.
- tx_req_o is never issued unless tx_idle_i was high in the issue cycle.
- rst_n_i low at any time returns to reset values immediately; in-flight pulses are dropped.

Test Plan:
- Local request DWID=3, PMID=1, SBID=0, remote answers ACK 50 cycles after cfg byte.
  - Expect tx bytes F1 then 0x34.
  - Expect configuration_done_o low from cycle after request until cycle after ACK; no set_std_config_o.
- Remote sends F1 then 0x1B.
  - Expect str_en_o one cycle with data_width_o=1, parity_mode_o=2, stop_bits_o=3.
  - Expect ACK F2 transmitted; configuration_done_o returns to 1 after tx_done_i.
- TIMEOUT_CYCLES=20, MAX_RETRY=2, no ACK.
  - Expect exactly 3 SYN/cfg pairs transmitted, then one set_std_config_o pulse and IDLE.
- send_req_i and rx SYN in the same cycle.
  - Expect responder path first: str_en_o, ACK sent.
  - Expect the pending local request sent next (F1 + cfg byte).
- Remote F1 then silence for TIMEOUT_CYCLES.
  - Expect return to IDLE, no str_en_o, no tx_req_o.
- Assert rst_n_i during WAIT_ACK.
  - Expect configuration_done_o=1 and all outputs at reset values asynchronously; a later ACK byte is ignored.
